wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of Wishbone master ports, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 32: data bus width in bits (8, 16, 32 or 64).
REQ-003 Parameter ADDR_WIDTH, default 32: address bus width in bits.
REQ-004 Parameter SELECT_WIDTH, default DATA_WIDTH/8: byte select width.
REQ-005 Parameter TIMEOUT_CYCLES, default 255: stall cycles before a timeout error; 0 disables the watchdog.
REQ-006 Port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Ports wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_stb_i, wbm_cyc_i, inputs, each NUM_MASTERS times the per-signal width, packed with master i at slice i: master requests.
REQ-009 Ports wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o, outputs, each NUM_MASTERS times the per-signal width, packed: per-master responses.
REQ-010 Ports wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_stb_o, wbs_cyc_o, outputs, single-slave width: the forwarded request.
REQ-011 Ports wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i, inputs, single-slave width: the slave response.
REQ-012 Port grant_o, output, NUM_MASTERS bits: one-hot current grant, all zero when idle.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANTED.
REQ-014 In IDLE, when any wbm_cyc_i bit is set, the arbiter SHALL register a one-hot grant and enter GRANTED on the next edge.
  - Search starts at index (last_grant+1) mod NUM_MASTERS and runs round-robin.
REQ-015 Arbitration latency SHALL be exactly one cycle: a master raising cyc in cycle n sees wbs_cyc_o/wbs_stb_o driven in cycle n+1 if it wins.
REQ-016 In GRANTED, the granted master's adr/dat/sel/we/stb/cyc SHALL be combinationally forwarded to the wbs_* outputs.
REQ-017 In IDLE, wbs_cyc_o, wbs_stb_o and wbs_we_o SHALL be 0; wbs_adr_o, wbs_dat_o and wbs_sel_o SHALL be 0.
REQ-018 wbs_ack_i, wbs_err_i and wbs_rty_i SHALL be routed only to the granted master; all other masters see 0.
REQ-019 wbs_dat_i SHALL be routed to the granted master's wbm_dat_o slice; all other slices read 0.
REQ-020 GRANTED SHALL be held while the granted master's cyc is 1, regardless of other requests (lock for block and RMW cycles).
REQ-021 When the granted master's cyc is 0, the arbiter SHALL, on the next edge:
  - return to IDLE;
  - record last_grant as that master's index;
  - clear grant_o.
  This enforces at least one IDLE cycle between owners.
REQ-022 Watchdog (TIMEOUT_CYCLES>0):
  - An 8-to-16-bit counter increments each GRANTED cycle with granted stb=1 and wbs_ack_i, wbs_err_i and wbs_rty_i all 0.
  - The counter clears on any response, when stb=0, and in IDLE.
REQ-023 When the counter equals TIMEOUT_CYCLES, the granted master's wbm_err_o SHALL be 1 for exactly that cycle and the counter SHALL clear.
  - wbs_stb_o is forced to 0 in that cycle.
REQ-024 A simultaneous slave ack and timeout terminal count SHALL resolve to the ack; no err is issued.
REQ-025 A master that drops cyc mid-transfer SHALL cause immediate wbs_cyc_o/wbs_stb_o deassertion (combinational forward) and a release on the next edge.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL reset to:
  - state IDLE;
  - grant_o=0;
  - last_grant=NUM_MASTERS-1, so master 0 wins first;
  - watchdog counter=0.
REQ-027 rst asserted during GRANTED SHALL abort the grant; all wbs_* strobes are 0 from the cycle after reset is sampled.

Structure
REQ-028 No shared package is needed: state encodings and the counter width are local constants derived from TIMEOUT_CYCLES.
REQ-029 Round-robin selection SHALL be a combinational sub-module wb_rr_pick.
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot pick, valid.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Reset, then masters 0 and 1 both raise cyc at cycle 0 -> grant_o=01 at cycle 1, wbs_cyc_o=1 at cycle 1.
  - Master 0 releases while master 1 is still requesting -> one IDLE cycle, then grant_o=10; master 0 re-requesting waits until master 1 releases.
  - Master 0 holds cyc over 4 acked strobes while master 1 requests -> grant stays 01 throughout; master 1 sees ack=0.
  - Slave never acks, TIMEOUT_CYCLES=4 -> wbm_err_o[0]=1 on the 5th stalled cycle for one cycle; wbs_stb_o=0 in that cycle.
  - Ack arrives on the terminal-count cycle -> ack forwarded, err=0.
  - rst pulsed mid-grant -> grant_o=0 and wbs_cyc_o=0 the next cycle; master 0 wins the next arbitration.

Source files
------------

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: the search starts one index past last_i
// and wraps, so the most recent owner has the lowest priority.
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  pick_o,
  output logic          valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to single-slave Wishbone arbiter: round-robin grant, bus lock while
// the owner holds cyc, and a stall watchdog that answers a hung slave with err.
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    wbm_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    wbm_dat_i,
  input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]               wbm_we_i,
  input  logic [NUM_MASTERS-1:0]               wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]               wbm_cyc_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]    wbm_dat_o,
  output logic [NUM_MASTERS-1:0]               wbm_ack_o,
  output logic [NUM_MASTERS-1:0]               wbm_err_o,
  output logic [NUM_MASTERS-1:0]               wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]                wbs_adr_o,
  output logic [DATA_WIDTH-1:0]                wbs_dat_o,
  output logic [SELECT_WIDTH-1:0]              wbs_sel_o,
  output logic                                 wbs_we_o,
  output logic                                 wbs_stb_o,
  output logic                                 wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]                wbs_dat_i,
  input  logic                                 wbs_ack_i,
  input  logic                                 wbs_err_i,
  input  logic                                 wbs_rty_i,
  output logic [NUM_MASTERS-1:0]               grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (TW < 8) ? 8 : ((TW > 16) ? 16 : TW);
  localparam logic [CW-1:0] T_TERM = CW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
  logic [IW-1:0]          last_q, last_d, gidx;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pick_vld, g_cyc, g_stb, resp, tmo_hit, tmo_err;

  wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req_i   (wbm_cyc_i),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  // grant_q is all-zero in IDLE, so these reductions also encode the state
  assign g_cyc   = |(grant_q & wbm_cyc_i);
  assign g_stb   = |(grant_q & wbm_cyc_i & wbm_stb_i);
  assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign tmo_hit = WD_EN && g_stb && (cnt_q == T_TERM);
  assign tmo_err = tmo_hit && !resp;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) gidx = IW'(i);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANTED;
          grant_d = pick;
        end
      end
      GRANTED: begin
        if (WD_EN && g_stb && !resp && !tmo_hit) cnt_d = cnt_q + 1'b1;
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbm_dat_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        wbs_adr_o = wbm_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wbs_dat_o = wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        wbs_sel_o = wbm_sel_i[i*SELECT_WIDTH +: SELECT_WIDTH];
        wbm_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = wbs_dat_i;
        wbm_ack_o[i] = wbs_ack_i;
        wbm_err_o[i] = wbs_err_i | tmo_err;
        wbm_rty_o[i] = wbs_rty_i;
      end
    end
  end

  // The terminal-count strobe is withdrawn even when a late ack arrives, so
  // wbs_stb_o never depends combinationally on the slave response.
  assign wbs_cyc_o = g_cyc;
  assign wbs_stb_o = g_stb & ~tmo_hit;
  assign wbs_we_o  = |(grant_q & wbm_we_i);
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed cycle table for the lock/release/timeout/reset
// corners, then randomized traffic checked against an ownership-level model.
module tb_wb_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [N-1:0]    grant_o;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] cyc, stb;
    logic       ack;
    logic [1:0] g;
    logic       scyc, sstb;
    logic [1:0] mack, merr;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic [1:0] c, input logic [1:0] s,
                      input logic a, input logic [1:0] g, input logic sc,
                      input logic ss, input logic [1:0] ma, input logic [1:0] me,
                      input int rep);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.g = g;
    v.scyc = sc; v.sstb = ss; v.mack = ma; v.merr = me;
    for (int i = 0; i < rep; i++) vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model state: owning master (-1 = bus idle), previous owner, stall run
  int owner, last, stall, o, m;
  logic act_stb, resp, tmo;
  logic [N-1:0] eg, emack, emerr, emrty;
  logic escyc, esstb, eswe;
  logic [AW-1:0] eadr;
  logic [DW-1:0] edat;
  logic [SW-1:0] esel;
  logic [N*DW-1:0] emdat;

  initial begin
    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbm_we_i = '0; wbm_stb_i = '0; wbm_cyc_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    repeat (2) @(negedge clk);

    //   rst  cyc    stb    ack  grant  scyc sstb mack   merr   rep
    addv(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1); // reset state
    addv(0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1); // both raise cyc
    addv(0, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00, 4); // m0 locked, 4 acks
    addv(0, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 4); // stalled 1..4
    addv(0, 2'b11, 2'b11, 0, 2'b01, 1, 0, 2'b00, 2'b01, 1); // 5th stall: timeout
    addv(0, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 4); // stall again
    addv(0, 2'b11, 2'b11, 1, 2'b01, 1, 0, 2'b01, 2'b00, 1); // ack on terminal count
    addv(0, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1); // m0 drops cyc
    addv(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1); // idle gap
    addv(0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 2); // m1 owns, m0 waits
    addv(0, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00, 1); // m1 releases
    addv(0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1);
    addv(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1); // m0 granted
    addv(1, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1); // rst mid-grant
    addv(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1); // aborted
    addv(0, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00, 1); // m0 wins after reset
    addv(0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1);
    addv(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst; wbm_cyc_i = vq[k].cyc; wbm_stb_i = vq[k].stb; wbs_ack_i = vq[k].ack;
      #1;
      chk($sformatf("v%0d grant", k), 128'(grant_o),   128'(vq[k].g));
      chk($sformatf("v%0d s_cyc", k), 128'(wbs_cyc_o), 128'(vq[k].scyc));
      chk($sformatf("v%0d s_stb", k), 128'(wbs_stb_o), 128'(vq[k].sstb));
      chk($sformatf("v%0d m_ack", k), 128'(wbm_ack_o), 128'(vq[k].mack));
      chk($sformatf("v%0d m_err", k), 128'(wbm_err_o), 128'(vq[k].merr));
    end

    // randomized phase, starting from a fresh reset
    @(negedge clk);
    rst = 1'b1; wbm_cyc_i = '0; wbm_stb_i = '0; wbs_ack_i = 1'b0;
    owner = -1; last = N - 1; stall = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (wbm_cyc_i[i]) wbm_cyc_i[i] = ($urandom_range(0, 9) != 0);
        else              wbm_cyc_i[i] = ($urandom_range(0, 3) == 0);
        wbm_stb_i[i] = ($urandom_range(0, 3) != 0);
        wbm_we_i[i]  = 1'($urandom);
        wbm_adr_i[i*AW +: AW] = AW'($urandom);
        wbm_dat_i[i*DW +: DW] = DW'($urandom);
        wbm_sel_i[i*SW +: SW] = SW'($urandom);
      end
      wbs_ack_i = ($urandom_range(0, 5) == 0);
      wbs_err_i = ($urandom_range(0, 15) == 0);
      wbs_rty_i = ($urandom_range(0, 15) == 0);
      wbs_dat_i = DW'($urandom);
      #1;
      eg = '0; emack = '0; emerr = '0; emrty = '0; emdat = '0;
      escyc = 1'b0; esstb = 1'b0; eswe = 1'b0; eadr = '0; edat = '0; esel = '0;
      act_stb = 1'b0; tmo = 1'b0;
      resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
      if (owner >= 0) begin
        o = owner;
        eg[o]   = 1'b1;
        escyc   = wbm_cyc_i[o];
        act_stb = wbm_cyc_i[o] && wbm_stb_i[o];
        tmo     = act_stb && (stall == TO);
        esstb   = act_stb && !tmo;
        eswe    = wbm_we_i[o];
        eadr    = wbm_adr_i[o*AW +: AW];
        edat    = wbm_dat_i[o*DW +: DW];
        esel    = wbm_sel_i[o*SW +: SW];
        emack[o] = wbs_ack_i;
        emerr[o] = wbs_err_i || (tmo && !resp);
        emrty[o] = wbs_rty_i;
        emdat[o*DW +: DW] = wbs_dat_i;
      end
      chk("r grant", 128'(grant_o),   128'(eg));
      chk("r s_cyc", 128'(wbs_cyc_o), 128'(escyc));
      chk("r s_stb", 128'(wbs_stb_o), 128'(esstb));
      chk("r s_we",  128'(wbs_we_o),  128'(eswe));
      chk("r s_adr", 128'(wbs_adr_o), 128'(eadr));
      chk("r s_dat", 128'(wbs_dat_o), 128'(edat));
      chk("r s_sel", 128'(wbs_sel_o), 128'(esel));
      chk("r m_ack", 128'(wbm_ack_o), 128'(emack));
      chk("r m_err", 128'(wbm_err_o), 128'(emerr));
      chk("r m_rty", 128'(wbm_rty_o), 128'(emrty));
      chk("r m_dat", 128'(wbm_dat_o), 128'(emdat));
      @(posedge clk);
      if (rst) begin
        owner = -1; last = N - 1; stall = 0;
      end else if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          m = (last + k) % N;
          if (owner < 0 && wbm_cyc_i[m]) owner = m;
        end
        stall = 0;
      end else begin
        if (act_stb && !resp && !tmo) stall++;
        else stall = 0;
        if (!wbm_cyc_i[owner]) begin
          last = owner; owner = -1; stall = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
